// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the hazard controller slice.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
package hazard_ctrl_pkg;

  localparam int HAZARD_NREG         = 32;
  localparam int HAZARD_REG_W        = $clog2(HAZARD_NREG);
  localparam int HAZARD_FLUSH_CYCLES = 2;
  localparam int HAZARD_FCNT_W       = 4;

  typedef logic [HAZARD_REG_W-1:0] reg_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side handshake bundle observed and driven by hazard_ctrl.
// The master side is the pipeline, the slave side is the hazard controller.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = HAZARD_REG_W
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_fire;
  logic             id_is_load;
  logic [REG_W-1:0] id_rd;
  logic             wb_fire;
  logic             wb_is_load;
  logic [REG_W-1:0] wb_rd;
  logic             ex_redirect;
  logic             bubble;
  logic             flush;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_fire, id_is_load, id_rd, wb_fire, wb_is_load, wb_rd, ex_redirect,
    input  bubble, flush
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_fire, id_is_load, id_rd, wb_fire, wb_is_load, wb_rd, ex_redirect,
    output bubble, flush
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Load-use scoreboard: one pending bit per register for an outstanding load.
// Part of hazard_ctrl (see HAZARD_STATS_EN in the top for optional stats).
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG  = HAZARD_NREG,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rd1_idx,
  input  logic [REG_W-1:0] rd2_idx,
  input  logic [REG_W-1:0] rd3_idx,
  output logic             rd1_busy,
  output logic             rd2_busy,
  output logic             rd3_busy
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Set is applied after clear so a younger load to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != '0)) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rd1_busy = pending_q[rd1_idx];
  assign rd2_busy = pending_q[rd2_idx];
  assign rd3_busy = pending_q[rd3_idx];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall plus multi-cycle redirect flush.
// Define HAZARD_STATS_EN to build the bubble/flush statistics counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG         = HAZARD_NREG,
  parameter int REG_W        = $clog2(NREG),
  parameter int FLUSH_CYCLES = HAZARD_FLUSH_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stat_bubbles,
  output logic [CNT_W-1:0] stat_flushes
);

  localparam logic [HAZARD_FCNT_W-1:0] FLUSH_LOAD = HAZARD_FCNT_W'(FLUSH_CYCLES - 1);

  logic                     rs1_busy;
  logic                     rs2_busy;
  logic                     rd_busy;
  logic                     hazard;
  logic                     flush_raw;
  logic [HAZARD_FCNT_W-1:0] fcnt_q;
  logic [HAZARD_FCNT_W-1:0] fcnt_d;

  hazard_scoreboard #(
    .NREG  (NREG),
    .REG_W (REG_W)
  ) u_scoreboard (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .set_en   (hz.id_fire & hz.id_is_load),
    .set_idx  (hz.id_rd),
    .clr_en   (hz.wb_fire & hz.wb_is_load),
    .clr_idx  (hz.wb_rd),
    .rd1_idx  (hz.id_rs1),
    .rd2_idx  (hz.id_rs2),
    .rd3_idx  (hz.id_rd),
    .rd1_busy (rs1_busy),
    .rd2_busy (rs2_busy),
    .rd3_busy (rd_busy)
  );

  // A redirect reloads rather than adds, so back-to-back redirects only extend.
  always_comb begin
    fcnt_d = fcnt_q;
    if (hz.ex_redirect) begin
      fcnt_d = FLUSH_LOAD;
    end else if (fcnt_q != '0) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign flush_raw = hz.ex_redirect | (fcnt_q != '0);
  assign hazard    = (hz.id_rs1_used & rs1_busy) |
                     (hz.id_rs2_used & rs2_busy) |
                     (hz.id_is_load  & rd_busy);

  // Gated by reset so a live redirect input cannot leak out while in reset.
  assign hz.flush  = aresetn & flush_raw;
  assign hz.bubble = aresetn & hz.id_valid & ~flush_raw & hazard;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stat_bubbles_q;
  logic [CNT_W-1:0] stat_bubbles_d;
  logic [CNT_W-1:0] stat_flushes_q;
  logic [CNT_W-1:0] stat_flushes_d;

  always_comb begin
    stat_bubbles_d = stat_bubbles_q + CNT_W'(hz.bubble);
    stat_flushes_d = stat_flushes_q + CNT_W'(hz.ex_redirect);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_bubbles_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_bubbles_q <= stat_bubbles_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_bubbles = stat_bubbles_q;
  assign stat_flushes = stat_flushes_q;
`else
  assign stat_bubbles = '0;
  assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (FLUSH_CYCLES=3); stats expectations
// follow HAZARD_STATS_EN.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic valid;
    reg_t rs1;
    logic u1;
    reg_t rs2;
    logic u2;
    logic fire;
    logic ld;
    reg_t rd;
    logic wbf;
    logic wbl;
    reg_t wbrd;
    logic redir;
    logic exp_b;
    logic exp_f;
  } vec_t;

  logic             aclk;
  logic             aresetn;
  logic [CNT_W-1:0] stat_bubbles;
  logic [CNT_W-1:0] stat_flushes;

  int vectors;
  int miscompares;

  vec_t tbl[$];
  vec_t seq[$];

  hazard_ctrl_if #(.REG_W(HAZARD_REG_W)) hz ();

  hazard_ctrl #(
    .NREG         (HAZARD_NREG),
    .REG_W        (HAZARD_REG_W),
    .FLUSH_CYCLES (3),
    .CNT_W        (CNT_W)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .hz           (hz),
    .stat_bubbles (stat_bubbles),
    .stat_flushes (stat_flushes)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic vec_t mk(input logic valid, input reg_t rs1, input logic u1,
                              input reg_t rs2, input logic u2, input logic fire,
                              input logic ld, input reg_t rd, input logic wbf,
                              input logic wbl, input reg_t wbrd, input logic redir,
                              input logic exp_b, input logic exp_f);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.fire = fire; v.ld = ld; v.rd = rd; v.wbf = wbf; v.wbl = wbl;
    v.wbrd = wbrd; v.redir = redir; v.exp_b = exp_b; v.exp_f = exp_f;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    hz.id_valid    = v.valid;
    hz.id_rs1      = v.rs1;
    hz.id_rs1_used = v.u1;
    hz.id_rs2      = v.rs2;
    hz.id_rs2_used = v.u2;
    hz.id_fire     = v.fire;
    hz.id_is_load  = v.ld;
    hz.id_rd       = v.rd;
    hz.wb_fire     = v.wbf;
    hz.wb_is_load  = v.wbl;
    hz.wb_rd       = v.wbrd;
    hz.ex_redirect = v.redir;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic exp_b, input logic exp_f);
    vectors++;
    if (hz.bubble !== exp_b) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] bubble: got %b expected %b", tag, idx, hz.bubble, exp_b);
    end
    if (hz.flush !== exp_f) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] flush: got %b expected %b", tag, idx, hz.flush, exp_f);
    end
  endtask

  task automatic checkStat(input string tag, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Each entry is one decode cycle: drive at the falling edge, check before the rising edge.
  task automatic runSeq(input string tag);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge aclk);
      applyStimulus(seq[i]);
      #1;
      checkOutput(tag, i, seq[i].exp_b, seq[i].exp_f);
    end
    seq.delete();
  endtask

  initial begin
    vec_t idle;
    logic [CNT_W-1:0] exp_sb;
    logic [CNT_W-1:0] exp_sf;

    vectors     = 0;
    miscompares = 0;
    idle        = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0);

    // Reset state, with a live redirect and reader that must not leak out.
    aresetn = 1'b0;
    applyStimulus(mk(1,5,1,5,1, 1,1,5, 0,0,0, 1, 0,0));
    repeat (2) @(negedge aclk);
    #1;
    checkOutput("reset", 0, 1'b0, 1'b0);
    checkStat("reset stat_bubbles", stat_bubbles, '0);
    checkStat("reset stat_flushes", stat_flushes, '0);
    applyStimulus(idle);
    @(negedge aclk);
    aresetn = 1'b1;

    // Load-use, x0, same-cycle set/clear, WAW and non-load writeback.
    tbl.push_back(mk(1,0,0,0,0, 1,1,5, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,5,1,0,0, 0,0,0, 0,0,0, 0, 1,0));
    tbl.push_back(mk(1,5,1,0,0, 0,0,0, 0,0,0, 0, 1,0));
    tbl.push_back(mk(1,5,1,0,0, 0,0,0, 1,1,5, 0, 1,0));
    tbl.push_back(mk(1,5,1,0,0, 1,0,0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 1,0,0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,7, 1,1,7, 0, 0,0));
    tbl.push_back(mk(1,0,0,7,1, 0,0,0, 0,0,0, 0, 1,0));
    tbl.push_back(mk(1,0,0,0,0, 0,1,7, 0,0,0, 0, 1,0));
    tbl.push_back(mk(1,0,0,0,0, 0,1,7, 1,1,7, 0, 1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,7, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,7,0,0,0, 0,0,0, 0,0,0, 0, 0,0));
    tbl.push_back(mk(1,7,1,0,0, 0,0,0, 1,0,7, 0, 1,0));
    tbl.push_back(mk(1,7,1,0,0, 0,0,0, 0,0,0, 0, 1,0));
    tbl.push_back(mk(0,7,1,0,0, 0,0,0, 1,1,7, 0, 0,0));
    tbl.push_back(mk(1,7,1,0,0, 1,0,0, 0,0,0, 0, 0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge aclk);
      applyStimulus(tbl[i]);
      #1;
      checkOutput("tbl", i, tbl[i].exp_b, tbl[i].exp_f);
    end

    // Flush window of 3 cycles masks a pending x9 hazard; a redirect two cycles in extends it.
    seq.push_back(mk(1,0,0,0,0, 1,1,9, 0,0,0, 0, 0,0));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 1, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 1,0));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 1, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 1, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 1,0));
    runSeq("flush");

    // Asynchronous reset in the middle of a stall (x9 still pending).
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("rst_stall", 0, 1'b0, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checkOutput("rst_stall", 1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a flush window.
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1, 0,1));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,1));
    runSeq("rst_flush");
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("rst_flush", 2, 1'b0, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    seq.push_back(mk(1,9,1,0,0, 0,0,0, 0,0,0, 0, 0,0));
    runSeq("post_rst");

    // Statistics: four bubble cycles and two redirects after a fresh reset.
    aresetn = 1'b0;
    applyStimulus(idle);
    @(negedge aclk);
    aresetn = 1'b1;
    seq.push_back(mk(1,0,0,0,0, 1,1,3, 0,0,0, 0, 0,0));
    for (int i = 0; i < 4; i++) seq.push_back(mk(1,3,1,0,0, 0,0,0, 0,0,0, 0, 1,0));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 1,1,3, 0, 0,0));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1, 0,1));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1, 0,1));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,1));
    seq.push_back(mk(0,3,1,0,0, 0,0,0, 0,0,0, 0, 0,0));
    runSeq("stats");
`ifdef HAZARD_STATS_EN
    exp_sb = 4;
    exp_sf = 2;
`else
    exp_sb = 0;
    exp_sf = 0;
`endif
    checkStat("stat_bubbles", stat_bubbles, exp_sb);
    checkStat("stat_flushes", stat_flushes, exp_sf);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the rv32 core. It replaces the purely combinational flush/bubble monitor with a load-use scoreboard, which stalls decode until an outstanding load retires. It also has a multi-cycle flush sequencer that covers the fetch pipeline depth after a redirect. It sits beside the decode/execute/memory/writeback stages, observes their handshakes, and drives `bubble` and `flush` back to fetch/decode.

## Interface
Parameters:
- `NREG`, 32, number of architectural registers; x0 is never tracked.
- `REG_W`, `$clog2(NREG)`, register index width.
- `FLUSH_CYCLES`, 2, cycles `flush` stays high per redirect; legal range 1..15.
- `CNT_W`, 32, statistics counter width; used only with `HAZARD_STATS_EN`.

Ports (one clock; reset asynchronous, active-low):
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs1`, `id_rs2` in REG_W: decode source indices.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_fire` in 1: decode→execute transfer this cycle (tvalid & tready).
- `id_is_load` in 1: instruction in decode is a LOAD.
- `id_rd` in REG_W: decode destination index.
- `wb_fire` in 1: writeback retires an instruction this cycle.
- `wb_is_load` in 1: retiring instruction is a load.
- `wb_rd` in REG_W: retiring destination.
- `ex_redirect` in 1: jump, or taken/mispredicted branch, resolved in execute (valid-qualified).
- `bubble` out 1: hold decode and inject a bubble into execute.
- `flush` out 1: kill fetch and decode contents.
- `stat_bubbles` out CNT_W: bubble cycles (`HAZARD_STATS_EN` only).
- `stat_flushes` out CNT_W: redirect events (`HAZARD_STATS_EN` only).

## Operation
- Scoreboard: `pending[NREG-1:0]`.
  - `id_fire & id_is_load & id_rd != 0` sets `pending[id_rd]`.
  - `wb_fire & wb_is_load` clears `pending[wb_rd]`.
  - Same-register set and clear in one cycle: set wins, because the new load is younger.
  - `pending[0]` is constant 0.
- `bubble = id_valid & ~flush & ((id_rs1_used & pending[id_rs1]) | (id_rs2_used & pending[id_rs2]) | (id_is_load & pending[id_rd]))`. The last term blocks a WAW load to a busy register, so each register has at most one outstanding load.
- Non-load RAW hazards are resolved by forwarding elsewhere and are not stalled here.
- Flush sequencer: 4-bit down-counter `fcnt`.
  - `ex_redirect` loads `FLUSH_CYCLES-1`.
  - Otherwise `fcnt` decrements to 0 and saturates there.
  - `flush = ex_redirect | (fcnt != 0)`.
  - A redirect arriving while `fcnt != 0` reloads the counter (extends the flush, no accumulation).
- The scoreboard is not cleared by flush: loads already past decode are older than the redirect and still retire.
- Reset mid-operation: all pending bits, `fcnt` and stats return to 0 asynchronously. Outputs are low during reset.

## Timing
- Reset values: `bubble` 0, `flush` 0, `stat_*` 0.
- `bubble` and `flush` are combinational from inputs and registered state in the same cycle. There is no output register.
- A scoreboard update at edge N is visible to `bubble` in cycle N+1. A load issuing in cycle N stalls a dependent instruction in decode from cycle N+1 up to and including the cycle of its `wb_fire`. The dependent instruction proceeds in the cycle after that.
- A redirect in cycle N gives `flush` high for cycles N..N+FLUSH_CYCLES-1.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stat_bubbles` increments every cycle `bubble` is 1.
  - `stat_flushes` increments every cycle `ex_redirect` is 1.
  - Both wrap modulo 2^CNT_W.
- `HAZARD_STATS_EN` undefined: the ports still exist, tie to 0, and no counter logic is synthesised.

## Structure
- `core` package gains:
  - `reg_t` (`logic [REG_W-1:0]`).
  - `HAZARD_FLUSH_CYCLES` default constant.
- Sub-module `hazard_scoreboard` holds the pending vector with set/clear ports and two read ports plus the rd check. `hazard_ctrl` holds the flush counter, the bubble combine and the stats.

## Test plan
- Load x5 issues (`id_fire`, `id_is_load`, `id_rd`=5). The next decode reads rs1=5. Expected: `bubble`=1 until `wb_fire`/`wb_is_load`/`wb_rd`=5, then 0 the next cycle.
- Load to x0, then a reader of x0. Expected: `bubble` never asserts.
- `ex_redirect` pulse with FLUSH_CYCLES=3. Expected: `flush` high exactly 3 cycles. A second redirect in cycle 2 gives 3 more cycles from there. `bubble` is 0 throughout even with a pending hazard.
- Same-cycle load issue to x7 and load retire of x7. Expected: `pending[7]` stays 1 and a reader of x7 bubbles.
- Assert `aresetn`=0 mid-stall and mid-flush. Expected: `bubble`=`flush`=0 immediately, and the scoreboard is clear after release.
- With `HAZARD_STATS_EN`: 4 bubble cycles and 2 redirects. Expected: `stat_bubbles`=4, `stat_flushes`=2.
